out_buff_drain: RTL
===================

Name: out_buff_drain

Overview:
Read-side sequencer for the double (even/odd) output buffer banks. On a start command it walks a contiguous address window, issues broadcast read enables and addresses to every row of both banks, and captures the 1-cycle-latency read data. It emits one row-vector per beat on a valid/ready stream toward the writeback path, alternating even then odd at each address. It sits directly downstream of the output buffer banks and drives their read-side control inputs.

Parameters:
num_pe_row, 16, rows per bank (row-vector width in words)
data_width_to_buff, 16, word width stored in each bank
nb_data, 8192, words per bank row; must be a power of two
addr_width, clogb2(nb_data), bank address width

Ports:
clk  in  1  clock
rst_AH  in  1  synchronous reset, active high
start  in  1  1-cycle pulse; launches a drain when idle
base_addr  in  addr_width  first address; sampled on accepted start
num_words  in  addr_width+1  addresses to drain, 0..nb_data; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse when the final beat is accepted
rEn_even_AH  out  num_pe_row  read enable to the even bank, active high, same value on all bits
rEn_odd_AH  out  num_pe_row  read enable to the odd bank, active high, same value on all bits
rAddr_even  out  num_pe_row*addr_width  read address, broadcast to all rows
rAddr_odd  out  num_pe_row*addr_width  read address, broadcast to all rows
buff_data_out_even  in  num_pe_row*data_width_to_buff  even bank read data, valid 1 cycle after its rEn
buff_data_out_odd  in  num_pe_row*data_width_to_buff  odd bank read data, valid 1 cycle after its rEn
m_valid  out  1  stream beat valid
m_ready  in  1  downstream accept
m_data  out  num_pe_row*data_width_to_buff  row-vector beat
m_is_odd  out  1  1 = beat came from the odd bank
m_last  out  1  final beat of the drain

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `rst_AH`.
- Reset values: state IDLE; busy, done, m_valid, m_last, m_is_odd, rEn_* all 0; rAddr_* 0; FIFO empty; counters 0.
- FSM states:
  - IDLE: start && num_words!=0 -> RUN; latch base_addr/num_words; busy=1.
  - IDLE: start && num_words==0 -> DONE; no reads issued.
  - RUN: issues reads. After the odd read of the final address is issued -> FLUSH.
  - FLUSH: waits until the FIFO is empty and no read is in flight, with the last beat accepted -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Read order: even@A, odd@A, even@A+1, odd@A+1, ... At most one bank is enabled per cycle; the other bank's rEn is 0.
- Address computation: A_k = (base_addr + k) mod nb_data, using natural addr_width wrap. rAddr of the idle bank holds its last value.
- Read latency: bank data is captured into the FIFO on the cycle after rEn.
- Credit rule: a read is issued in cycle t only if (FIFO occupancy + reads in flight) < 2. Capacity is the 2-entry output FIFO.
- Throughput: with m_ready held high, one beat per cycle is sustained.
- Latency: start accepted at cycle 0 -> first rEn at cycle 1 -> first m_valid at cycle 2.
- Stream rules:
  - m_data, m_is_odd and m_last are stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
  - m_last=1 only on the odd beat of the final address.
- Beat count: exactly 2*num_words beats per drain. num_words==nb_data drains the full bank, wrapping back to base_addr-1.
- start while busy: ignored; latched parameters are unchanged.
- rst_AH mid-drain: at the next edge, reads stop and the FIFO is flushed. No done pulse; m_valid=0.
- done and a new start in the same cycle: the new start is ignored (state is DONE, not IDLE).

Optional Feature:
- Macro OUT_DRAIN_RELU_EN.
- Defined: each m_data word is treated as signed two's complement; negative words are output as 0. This is applied combinationally at the FIFO output and adds no latency.
- Undefined: m_data is bit-exact bank data.

Decomposition:
- Package out_drain_pkg:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - FIFO_DEPTH=2 constant
  - row_vec_t typedef for a num_pe_row x data_width_to_buff packed array
  - beat struct {row_vec_t data; logic is_odd; logic last}
- Sub-module out_drain_fifo2: 2-entry FIFO of beat structs. It provides valid/ready on the output and occupancy to the credit logic.

Test Plan:
- Basic drain: base_addr=0x010, num_words=3, m_ready=1. Expect 6 beats: even@0x010, odd@0x010, even@0x011, odd@0x011, even@0x012, odd@0x012. m_last on beat 6; done 1 cycle after; first m_valid 2 cycles after start.
- Wrap-around: base_addr=0x1FFE, num_words=4. Expect rAddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001 on each bank; 8 beats.
- Backpressure: num_words=8, m_ready toggled 1,0,0,1 repeating. Expect no beat lost or duplicated; m_data held stable while stalled; occupancy+inflight never exceeds 2; 16 beats in order.
- Zero/ignored starts:
  - num_words=0: expect done 1 cycle later, no rEn, no m_valid.
  - Second start mid-drain with base_addr=0x100: expect it ignored and the original sequence unaffected.
- Reset mid-drain: assert rst_AH after the 3rd beat of a num_words=10 drain. Next cycle expect busy=0, m_valid=0, rEn=0, no done pulse. A fresh start then drains correctly.
- OUT_DRAIN_RELU_EN: bank word 0x8001 -> m_data 0x0000; 0x7FFF -> 0x7FFF. With the macro undefined, 0x8001 passes unchanged.

Source files
------------

// File: rtl/out_drain_pkg.sv
// Shared types for the output-buffer drain sequencer: FSM states, beat format and sizing.
package out_drain_pkg;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NUM_PE_ROW = 16;
  localparam int DATA_W     = 16;
  localparam int NB_DATA    = 8192;
  localparam int ADDR_W     = clogb2(NB_DATA);
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [NUM_PE_ROW-1:0][DATA_W-1:0] row_vec_t;

  typedef struct packed {
    row_vec_t data;
    logic     is_odd;
    logic     last;
  } beat_t;

endpackage

// File: rtl/out_drain_fifo2.sv
// Two-entry fall-through beat FIFO: an empty FIFO presents the incoming beat in the same cycle.
// No push-side ready; the upstream credit logic guarantees a push never meets a full FIFO.
module out_drain_fifo2
  import out_drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst_AH,
  input  logic       push_vld,
  input  beat_t      push_dat,
  output logic       pop_vld,
  input  logic       pop_rdy,
  output beat_t      pop_dat,
  output logic [1:0] occupancy
);

  beat_t      mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       empty;
  logic       do_write;
  logic       do_read;

  assign empty     = (count == 2'd0);
  assign pop_vld   = !empty || push_vld;
  assign pop_dat   = empty ? push_dat : mem[rd_ptr];
  // A beat that bypasses an empty FIFO and is accepted at once is never stored.
  assign do_write  = push_vld && !(empty && pop_rdy);
  assign do_read   = !empty && pop_rdy;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_AH) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= ~wr_ptr;
      if (do_read)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_write} - {1'b0, do_read};
    end
  end

endmodule

// File: rtl/out_buff_drain.sv
// Drains an address window of the even/odd output banks as even,odd row-vector beats; start->rEn 1 cycle, start->m_valid 2.
// Reads are credit-gated by the 2-entry FIFO under m_ready backpressure. OUT_DRAIN_RELU_EN clamps negative words to 0.
module out_buff_drain
  import out_drain_pkg::*;
#(
  parameter int num_pe_row         = NUM_PE_ROW,
  parameter int data_width_to_buff = DATA_W,
  parameter int nb_data            = NB_DATA,
  parameter int addr_width         = clogb2(nb_data)
) (
  input  logic                                     clk,
  input  logic                                     rst_AH,
  input  logic                                     start,
  input  logic [addr_width-1:0]                    base_addr,
  input  logic [addr_width:0]                      num_words,
  output logic                                     busy,
  output logic                                     done,
  output logic [num_pe_row-1:0]                    rEn_even_AH,
  output logic [num_pe_row-1:0]                    rEn_odd_AH,
  output logic [num_pe_row*addr_width-1:0]         rAddr_even,
  output logic [num_pe_row*addr_width-1:0]         rAddr_odd,
  input  logic [num_pe_row*data_width_to_buff-1:0] buff_data_out_even,
  input  logic [num_pe_row*data_width_to_buff-1:0] buff_data_out_odd,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [num_pe_row*data_width_to_buff-1:0] m_data,
  output logic                                     m_is_odd,
  output logic                                     m_last
);

  localparam logic [addr_width:0] CNT_ONE = (addr_width+1)'(1);

  state_t                state;
  state_t                state_nxt;
  logic [addr_width-1:0] base_q;
  logic [addr_width:0]   num_q;
  logic [addr_width:0]   idx;
  logic [addr_width-1:0] cur_addr;
  logic [addr_width-1:0] raddr_even_q;
  logic [addr_width-1:0] raddr_odd_q;
  logic [addr_width-1:0] raddr_even;
  logic [addr_width-1:0] raddr_odd;
  logic                  odd_phase;
  logic                  inflight;
  logic                  inflight_odd;
  logic                  inflight_last;
  logic                  credit_ok;
  logic                  issue;
  logic                  issue_even;
  logic                  issue_odd;
  logic                  final_addr;
  logic [1:0]            occupancy;
  beat_t                 push_dat;
  beat_t                 pop_dat;
  logic                  pop_vld;

  assign cur_addr   = base_q + idx[addr_width-1:0];
  assign final_addr = (idx == num_q - CNT_ONE);

  // A read may only launch if its beat is guaranteed a FIFO slot, counting the one still in flight.
  assign credit_ok  = ({1'b0, occupancy} + {2'b00, inflight}) < 3'd2;
  assign issue      = (state == RUN) && credit_ok;
  assign issue_even = issue && !odd_phase;
  assign issue_odd  = issue && odd_phase;

  assign raddr_even = issue_even ? cur_addr : raddr_even_q;
  assign raddr_odd  = issue_odd  ? cur_addr : raddr_odd_q;

  assign rEn_even_AH = {num_pe_row{issue_even}};
  assign rEn_odd_AH  = {num_pe_row{issue_odd}};
  assign rAddr_even  = {num_pe_row{raddr_even}};
  assign rAddr_odd   = {num_pe_row{raddr_odd}};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue_odd && final_addr) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        // The last beat is the youngest data, so its acceptance leaves nothing buffered or in flight.
        if (pop_vld && m_ready && pop_dat.last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_AH) begin
      state         <= IDLE;
      base_q        <= '0;
      num_q         <= '0;
      idx           <= '0;
      odd_phase     <= 1'b0;
      inflight      <= 1'b0;
      inflight_odd  <= 1'b0;
      inflight_last <= 1'b0;
      raddr_even_q  <= '0;
      raddr_odd_q   <= '0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_odd  <= odd_phase;
      inflight_last <= issue_odd && final_addr;
      raddr_even_q  <= raddr_even;
      raddr_odd_q   <= raddr_odd;
      if (state == IDLE && start) begin
        base_q    <= base_addr;
        num_q     <= num_words;
        idx       <= '0;
        odd_phase <= 1'b0;
      end else if (issue) begin
        odd_phase <= ~odd_phase;
        if (odd_phase) idx <= idx + CNT_ONE;
      end
    end
  end

  always_comb begin
    push_dat        = '0;
    push_dat.data   = inflight_odd ? buff_data_out_odd : buff_data_out_even;
    push_dat.is_odd = inflight_odd;
    push_dat.last   = inflight_last;
  end

  out_drain_fifo2 u_fifo (
    .clk       (clk),
    .rst_AH    (rst_AH),
    .push_vld  (inflight),
    .push_dat  (push_dat),
    .pop_vld   (pop_vld),
    .pop_rdy   (m_ready),
    .pop_dat   (pop_dat),
    .occupancy (occupancy)
  );

  assign m_valid  = pop_vld;
  assign m_is_odd = pop_dat.is_odd;
  assign m_last   = pop_dat.last;

`ifdef OUT_DRAIN_RELU_EN
  always_comb begin
    m_data = pop_dat.data;
    for (int i = 0; i < num_pe_row; i++) begin
      if (pop_dat.data[i][data_width_to_buff-1]) begin
        m_data[i*data_width_to_buff +: data_width_to_buff] = '0;
      end
    end
  end
`else
  assign m_data = pop_dat.data;
`endif

endmodule
